// File: rtl/mvu_controller_if.sv
// mvu_controller_if: host command and MVU control/address bundle for the job sequencer
interface mvu_controller_if #(
    parameter int BWBANKA = 9,
    parameter int BDBANKA = 14,
    parameter int BPREC   = 4,
    parameter int BLEN    = 9,
    parameter int BNOUT   = 9
);
    logic               start;
    logic [1:0]         cfg_mul_mode;
    logic [BPREC-1:0]   cfg_wprec;
    logic [BPREC-1:0]   cfg_iprec;
    logic [BLEN-1:0]    cfg_len;
    logic [BNOUT-1:0]   cfg_nout;
    logic [BWBANKA-1:0] cfg_wbase;
    logic [BDBANKA-1:0] cfg_dbase;
    logic [BDBANKA-1:0] cfg_obase;
    logic               busy;
    logic               done;
    logic [1:0]         mul_mode;
    logic               acc_clr;
    logic               acc_sh;
    logic [BWBANKA-1:0] rdw_addr;
    logic               rdd_en;
    logic [BDBANKA-1:0] rdd_addr;
    logic               quant_start;
    logic [BDBANKA-1:0] wrd_addr;

    modport master (
        output start, cfg_mul_mode, cfg_wprec, cfg_iprec, cfg_len, cfg_nout,
               cfg_wbase, cfg_dbase, cfg_obase,
        input  busy, done, mul_mode, acc_clr, acc_sh, rdw_addr, rdd_en, rdd_addr,
               quant_start, wrd_addr
    );

    modport slave (
        input  start, cfg_mul_mode, cfg_wprec, cfg_iprec, cfg_len, cfg_nout,
               cfg_wbase, cfg_dbase, cfg_obase,
        output busy, done, mul_mode, acc_clr, acc_sh, rdw_addr, rdd_en, rdd_addr,
               quant_start, wrd_addr
    );
endinterface

// File: rtl/mvu_controller.sv
// mvu_controller: expands a job descriptor into a bit-serial MVU accumulate/quantize schedule
module mvu_controller #(
    parameter int BWBANKA  = 9,
    parameter int BDBANKA  = 14,
    parameter int BPREC    = 4,
    parameter int BLEN     = 9,
    parameter int BNOUT    = 9,
    parameter int PIPE_LAT = 3
) (
    input logic clk,
    input logic rst,
    mvu_controller_if.slave bus
);
    localparam int SW = BPREC + 1;
    localparam int DW = $clog2(PIPE_LAT) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t state, nxt;
    logic [1:0]         mode;
    logic [BPREC-1:0]   wprec, iprec, wb, wb_hi, wb_hi_nxt, wb_lo, ib;
    logic [BLEN-1:0]    len, k;
    logic [BNOUT-1:0]   nout, o;
    logic [BWBANKA-1:0] wbase;
    logic [BDBANKA-1:0] dbase, obase;
    logic [SW-1:0]      s, s_top, cfg_top;
    logic [DW-1:0]      dcnt;
    logic zero_job, last_k, last_pair, last_s, last_word, last_drain, last_out;

    // loop bounds of the significance/pair/word nest and their terminal conditions
    always_comb begin
        s_top      = SW'(wprec) + SW'(iprec) - SW'(2);
        cfg_top    = SW'(bus.cfg_wprec) + SW'(bus.cfg_iprec) - SW'(2);
        wb_hi      = s < SW'(wprec) - SW'(1) ? BPREC'(s) : wprec - BPREC'(1);
        wb_hi_nxt  = s < SW'(wprec) ? BPREC'(s - SW'(1)) : wprec - BPREC'(1);
        wb_lo      = s >= SW'(iprec) ? BPREC'(s + SW'(1) - SW'(iprec)) : '0;
        ib         = BPREC'(s - SW'(wb));
        last_k     = k == len - BLEN'(1);
        last_pair  = wb == wb_lo;
        last_s     = s == '0;
        last_word  = last_k && last_pair && last_s;
        last_drain = dcnt == DW'(PIPE_LAT - 1);
        last_out   = o == nout - BNOUT'(1);
        zero_job   = bus.cfg_wprec == '0 || bus.cfg_iprec == '0 ||
                     bus.cfg_len == '0 || bus.cfg_nout == '0;
    end

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;

    // next-state: empty jobs skip straight to FIN, each output ends with a drain
    always_comb
        nxt = state == IDLE  ? (bus.start ? (zero_job ? FIN : RUN) : IDLE) :
              state == RUN   ? (last_word ? DRAIN : RUN) :
              state == DRAIN ? (last_drain ? (last_out ? FIN : RUN) : DRAIN) : IDLE;

    // job latch and schedule counters (k innermost, then wb, then s, then o)
    always_ff @(posedge clk) begin
        if (rst) begin
            mode  <= '0;
            wprec <= '0;
            iprec <= '0;
            len   <= '0;
            nout  <= '0;
            wbase <= '0;
            dbase <= '0;
            obase <= '0;
            o     <= '0;
            s     <= '0;
            wb    <= '0;
            k     <= '0;
            dcnt  <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                mode  <= bus.cfg_mul_mode;
                wprec <= bus.cfg_wprec;
                iprec <= bus.cfg_iprec;
                len   <= bus.cfg_len;
                nout  <= bus.cfg_nout;
                wbase <= bus.cfg_wbase;
                dbase <= bus.cfg_dbase;
                obase <= bus.cfg_obase;
                o     <= '0;
                k     <= '0;
                s     <= cfg_top;
                wb    <= bus.cfg_wprec - BPREC'(1);
            end
            if (state == RUN) begin
                k    <= last_k ? '0 : k + BLEN'(1);
                dcnt <= '0;
                if (last_k && !last_pair)
                    wb <= wb - BPREC'(1);
                if (last_k && last_pair && !last_s) begin
                    s  <= s - SW'(1);
                    wb <= wb_hi_nxt;
                end
            end
            if (state == DRAIN) begin
                dcnt <= dcnt + DW'(1);
                if (last_drain && !last_out) begin
                    o  <= o + BNOUT'(1);
                    s  <= s_top;
                    wb <= wprec - BPREC'(1);
                end
            end
        end
    end

    // MVU control and address outputs decoded from state and counters
    always_comb begin
        bus.busy        = state == RUN || state == DRAIN;
        bus.done        = state == FIN;
        bus.mul_mode    = mode;
        bus.rdd_en      = state == RUN;
        bus.acc_clr     = state == RUN && k == '0 && s == s_top && wb == wprec - BPREC'(1);
        bus.acc_sh      = state == RUN && k == '0 && s != s_top && wb == wb_hi;
        bus.rdw_addr    = state == RUN ? BWBANKA'(32'(wbase) +
                          (32'(o) * 32'(wprec) + 32'(wb)) * 32'(len) + 32'(k)) : '0;
        bus.rdd_addr    = state == RUN ? BDBANKA'(32'(dbase) + 32'(ib) * 32'(len) + 32'(k)) : '0;
        bus.quant_start = state == DRAIN && last_drain;
        bus.wrd_addr    = state == DRAIN && last_drain ? BDBANKA'(32'(obase) + 32'(o)) : '0;
    end
endmodule

// File: tb/tb_mvu_controller.sv
// tb_mvu_controller: per-cycle comparison of the sequencer against a loop-nest schedule model
module tb_mvu_controller;
    localparam int PL = 3;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [1:0]  mode;
        logic        clr;
        logic        sh;
        logic        en;
        logic [8:0]  wa;
        logic [13:0] da;
        logic        q;
        logic [13:0] oa;
    } ent_t;

    logic clk = 0;
    logic rst = 1;
    ent_t exp_q[$];
    ent_t ce, ca;
    logic [1:0] prev_mode = '0;
    int errors = 0, checks = 0, cyc = 0, base = 0;
    int q_seen = 0, d_seen = 0, en_seen = 0;

    mvu_controller_if bus();
    mvu_controller #(.PIPE_LAT(PL)) dut (.clk(clk), .rst(rst), .bus(bus));

    // free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // compare DUT outputs with the model's expectation for this cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            ca.busy = bus.busy;
            ca.done = bus.done;
            ca.mode = bus.mul_mode;
            ca.clr  = bus.acc_clr;
            ca.sh   = bus.acc_sh;
            ca.en   = bus.rdd_en;
            ca.wa   = bus.rdw_addr;
            ca.da   = bus.rdd_addr;
            ca.q    = bus.quant_start;
            ca.oa   = bus.wrd_addr;
            q_seen  += int'(ca.q);
            d_seen  += int'(ca.done);
            en_seen += int'(ca.en);
            if (!ce.en) begin
                ca.wa = '0; ca.da = '0; ce.wa = '0; ce.da = '0;
            end
            if (!ce.q) begin
                ca.oa = '0; ce.oa = '0;
            end
            checks++;
            if (ca !== ce) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, ca, ce);
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // schedule straight from the definition: o, s, wb, k loop nest, then drain, FIN, idle
    task automatic build(input int md, wp, ip, ln, no, wbv, dbv, obv);
        ent_t e;
        int w, first, lo, hi;
        e = '0;
        e.mode = prev_mode;
        exp_q.push_back(e);
        if (wp != 0 && ip != 0 && ln != 0 && no != 0) begin
            for (int o = 0; o < no; o++) begin
                w = 0;
                for (int s = wp + ip - 2; s >= 0; s--) begin
                    first = 1;
                    hi = s < wp - 1 ? s : wp - 1;
                    lo = s - ip + 1 > 0 ? s - ip + 1 : 0;
                    for (int wb = hi; wb >= lo; wb--) begin
                        for (int k = 0; k < ln; k++) begin
                            e = '0;
                            e.busy = 1; e.mode = 2'(md); e.en = 1;
                            e.clr = w == 0;
                            e.sh = first == 1 && s != wp + ip - 2;
                            e.wa = 9'(wbv + (o * wp + wb) * ln + k);
                            e.da = 14'(dbv + (s - wb) * ln + k);
                            exp_q.push_back(e);
                            first = 0;
                            w++;
                        end
                    end
                end
                for (int d = 1; d <= PL; d++) begin
                    e = '0;
                    e.busy = 1; e.mode = 2'(md);
                    e.q = d == PL;
                    e.oa = 14'(obv + o);
                    exp_q.push_back(e);
                end
            end
        end
        e = '0; e.done = 1; e.mode = 2'(md);
        exp_q.push_back(e);
        e = '0; e.mode = 2'(md);
        exp_q.push_back(e);
        exp_q.push_back(e);
        prev_mode = 2'(md);
    endtask

    task automatic start_job(input int md, wp, ip, ln, no, wbv, dbv, obv);
        base = exp_q.size();
        build(md, wp, ip, ln, no, wbv, dbv, obv);
        bus.cfg_mul_mode = 2'(md);
        bus.cfg_wprec = 4'(wp);
        bus.cfg_iprec = 4'(ip);
        bus.cfg_len = 9'(ln);
        bus.cfg_nout = 9'(no);
        bus.cfg_wbase = 9'(wbv);
        bus.cfg_dbase = 14'(dbv);
        bus.cfg_obase = 14'(obv);
        bus.start = 1;
    endtask

    task automatic finish_job(input bit hold);
        int g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            @(posedge clk); #1;
            g++;
            if (!hold || exp_q.size() <= 2) bus.start = 0;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        bus.start = 0;
    endtask

    initial begin
        ent_t e;
        int q0, d0, e0, md, wp, ip, ln, no;
        bus.start = 0;
        bus.cfg_mul_mode = '0; bus.cfg_wprec = '0; bus.cfg_iprec = '0; bus.cfg_len = '0;
        bus.cfg_nout = '0; bus.cfg_wbase = '0; bus.cfg_dbase = '0; bus.cfg_obase = '0;
        @(posedge clk); #1;
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 0;
        exp_q.push_back('0);
        @(posedge clk); #1;

        start_job(2, 1, 1, 4, 1, 0, 'h10, 'h20);
        chk("t1_clr_c1", exp_q[base+1].clr, 1);
        chk("t1_rdd_c4", exp_q[base+4].da, 'h13);
        chk("t1_rdw_c4", exp_q[base+4].wa, 3);
        chk("t1_quant_c7", exp_q[base+7].q, 1);
        chk("t1_wrd_c7", exp_q[base+7].oa, 'h20);
        chk("t1_done_c8", exp_q[base+8].done, 1);
        chk("t1_busy_c8", exp_q[base+8].busy, 0);
        finish_job(0);

        start_job(1, 2, 2, 2, 1, 0, 0, 5);
        chk("t2_sh_w3", exp_q[base+3].sh, 1);
        chk("t2_sh_w7", exp_q[base+7].sh, 1);
        chk("t2_sh_w5", exp_q[base+5].sh, 0);
        chk("t2_rdd_w1", exp_q[base+1].da, 2);
        chk("t2_rdd_w3", exp_q[base+3].da, 0);
        chk("t2_rdd_w8", exp_q[base+8].da, 1);
        finish_job(0);

        q0 = q_seen; d0 = d_seen;
        start_job(3, 1, 2, 1, 3, 5, 0, 'h100);
        chk("t3_rdw_o1", exp_q[base+6].wa, 6);
        chk("t3_rdw_o2", exp_q[base+11].wa, 7);
        chk("t3_wrd_o1", exp_q[base+10].oa, 'h101);
        finish_job(0);
        chk("t3_quant_count", q_seen - q0, 3);
        chk("t3_done_count", d_seen - d0, 1);

        q0 = q_seen; d0 = d_seen; e0 = en_seen;
        start_job(1, 2, 2, 0, 2, 0, 0, 0);
        finish_job(0);
        chk("len0_rdd_en", en_seen - e0, 0);
        chk("len0_quant", q_seen - q0, 0);
        chk("len0_done", d_seen - d0, 1);

        d0 = d_seen;
        start_job(2, 2, 2, 4, 2, 3, 7, 9);
        repeat (5) begin
            @(posedge clk); #1;
            bus.start = 0;
        end
        rst = 1;
        e = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e);
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 0;
        prev_mode = '0;
        @(posedge clk); #1;
        chk("rst_no_done", d_seen - d0, 0);
        start_job(3, 2, 3, 2, 2, 1, 2, 3);
        finish_job(0);

        d0 = d_seen;
        start_job(1, 1, 1, 2, 1, 'h1FF, 0, 0);
        chk("wrap_rdw_w1", exp_q[base+1].wa, 'h1FF);
        chk("wrap_rdw_w2", exp_q[base+2].wa, 0);
        finish_job(1);
        chk("hold_one_job", d_seen - d0, 1);

        for (int j = 0; j < 40; j++) begin
            md = int'($urandom_range(0, 3));
            wp = int'($urandom_range(1, 4));
            ip = int'($urandom_range(1, 4));
            ln = int'($urandom_range(1, 4));
            no = int'($urandom_range(1, 3));
            case ($urandom_range(0, 15))
                0: wp = 0;
                1: ip = 0;
                2: ln = 0;
                3: no = 0;
                default: ;
            endcase
            start_job(md, wp, ip, ln, no, int'($urandom_range(0, 511)),
                      int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
            finish_job($urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
